// File: rtl/cnn_conv_1x1_generic.sv
// Generic 1x1 convolution: loads CHANNEL_NUM_IN*CHANNEL_NUM_OUT weights, then runs one MAC per
// cycle over each kept channel-interleaved pixel, emitting saturated (optionally ReLU'd) outputs.
module cnn_conv_1x1_generic #(
  parameter int DATA_WIDTH      = 16,
  parameter int FRAC_BITS       = 8,
  parameter int CHANNEL_NUM_IN  = 304,
  parameter int CHANNEL_NUM_OUT = 256,
  parameter int IMAGE_WIDTH     = 306,
  parameter int IMAGE_HEIGHT    = 306,
  parameter int RELU_EN         = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] pxl_in,
  output logic                         ready_in,
  input  logic                         valid_weight_in,
  input  logic signed [DATA_WIDTH-1:0] weight_in,
  output logic                         weights_loaded,
  input  logic                         stride2,
  output logic signed [DATA_WIDTH-1:0] pxl_out,
  output logic                         valid_out
);

  localparam int ACC_W = 2*DATA_WIDTH + $clog2(CHANNEL_NUM_IN) + 1;
  localparam int NW    = CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
  localparam int CI_W  = (CHANNEL_NUM_IN  > 1) ? $clog2(CHANNEL_NUM_IN)  : 1;
  localparam int CO_W  = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
  localparam int WA_W  = (NW > 1)              ? $clog2(NW)              : 1;
  localparam int COL_W = (IMAGE_WIDTH  > 1)    ? $clog2(IMAGE_WIDTH)     : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1)    ? $clog2(IMAGE_HEIGHT)    : 1;

  localparam logic signed [ACC_W-1:0] P_MAX  = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] P_MIN  = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] P_ZERO = '0;

  typedef enum logic [1:0] {S_LOAD, S_COLLECT, S_COMPUTE} state_t;

  state_t                        r_state;
  logic signed [DATA_WIDTH-1:0]  r_wram  [NW];
  logic signed [DATA_WIDTH-1:0]  r_chbuf [CHANNEL_NUM_IN];
  logic [WA_W-1:0]               r_waddr;
  logic [WA_W-1:0]               r_raddr;
  logic [CI_W-1:0]               r_ci;
  logic [CO_W-1:0]               r_co;
  logic [COL_W-1:0]              r_col;
  logic [ROW_W-1:0]              r_row;
  logic                          r_stride;
  logic                          r_loaded;
  logic signed [ACC_W-1:0]       r_acc;
  logic signed [DATA_WIDTH-1:0]  r_pxl_out;
  logic                          r_valid;

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]        w_sum;
  logic                           w_first;
  logic                           w_stride;
  logic                           w_keep;
  logic                           w_last_ci;

  function automatic logic signed [DATA_WIDTH-1:0] sat_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC_BITS;
    if (s > P_MAX)      s = P_MAX;
    else if (s < P_MIN) s = P_MIN;
    return s[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] relu(input logic signed [DATA_WIDTH-1:0] v);
    if (RELU_EN != 0 && v < 0) return '0;
    return v;
  endfunction

  assign ready_in       = (r_state == S_COLLECT);
  assign weights_loaded = r_loaded;
  assign pxl_out        = r_pxl_out;
  assign valid_out      = r_valid;

  assign w_prod    = (2*DATA_WIDTH)'(r_wram[r_raddr]) * (2*DATA_WIDTH)'(r_chbuf[r_ci]);
  assign w_sum     = ((r_ci == '0) ? P_ZERO : r_acc) + ACC_W'(w_prod);
  assign w_last_ci = (r_ci == CI_W'(CHANNEL_NUM_IN-1));
  // stride2 is latched on the first beat of a frame; that beat itself uses the live input
  assign w_first   = (r_ci == '0) && (r_col == '0) && (r_row == '0);
  assign w_stride  = w_first ? stride2 : r_stride;
  assign w_keep    = !w_stride || (!r_row[0] && !r_col[0]);

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && valid_weight_in) r_wram[r_waddr] <= weight_in;
    if (r_state == S_COLLECT && valid_in)     r_chbuf[r_ci]   <= pxl_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_LOAD;
      r_waddr   <= '0;
      r_raddr   <= '0;
      r_ci      <= '0;
      r_co      <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_stride  <= 1'b0;
      r_loaded  <= 1'b0;
      r_acc     <= '0;
      r_pxl_out <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (valid_weight_in) begin
            if (r_waddr == WA_W'(NW-1)) begin
              r_waddr  <= '0;
              r_loaded <= 1'b1;
              r_state  <= S_COLLECT;
            end else begin
              r_waddr <= r_waddr + 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (valid_in) begin
            if (w_first) r_stride <= stride2;
            if (w_last_ci) begin
              r_ci <= '0;
              if (r_col == COL_W'(IMAGE_WIDTH-1)) begin
                r_col <= '0;
                r_row <= (r_row == ROW_W'(IMAGE_HEIGHT-1)) ? '0 : r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
              if (w_keep) begin
                r_co    <= '0;
                r_raddr <= '0;
                r_state <= S_COMPUTE;
              end
            end else begin
              r_ci <= r_ci + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          r_acc <= w_sum;
          if (r_raddr != WA_W'(NW-1)) r_raddr <= r_raddr + 1'b1;
          if (w_last_ci) begin
            r_ci      <= '0;
            r_pxl_out <= relu(sat_shift(w_sum));
            r_valid   <= 1'b1;
            if (r_co == CO_W'(CHANNEL_NUM_OUT-1)) begin
              r_co    <= '0;
              r_state <= S_COLLECT;
            end else begin
              r_co <= r_co + 1'b1;
            end
          end else begin
            r_ci <= r_ci + 1'b1;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_conv_1x1_generic.sv
// Bench for cnn_conv_1x1_generic: a plain-arithmetic model of the layer checks directed and
// random pixels on two instances (ReLU off / on) sharing the same inputs.
module tb_cnn_conv_1x1_generic;

  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int CIN  = 2;
  localparam int COUT = 2;
  localparam int IW   = 4;
  localparam int IH   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] pxl_in = '0;
  logic          valid_weight_in = 1'b0;
  logic [DW-1:0] weight_in = '0;
  logic          stride2 = 1'b0;

  logic          ready_in, weights_loaded, valid_out;
  logic [DW-1:0] pxl_out;
  logic          ready_r, loaded_r, valid_out_r;
  logic [DW-1:0] pxl_out_r;

  int n_cmp = 0;
  int n_err = 0;

  int m_w [CIN*COUT];
  int m_p [CIN];
  int m_pix = 0;
  bit m_stride = 0;

  always #5 clk = ~clk;

  cnn_conv_1x1_generic #(
    .DATA_WIDTH(DW), .FRAC_BITS(FRAC), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT),
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .RELU_EN(0)
  ) u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .ready_in(ready_in),
    .valid_weight_in(valid_weight_in), .weight_in(weight_in), .weights_loaded(weights_loaded),
    .stride2(stride2), .pxl_out(pxl_out), .valid_out(valid_out)
  );

  cnn_conv_1x1_generic #(
    .DATA_WIDTH(DW), .FRAC_BITS(FRAC), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT),
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .RELU_EN(1)
  ) u_relu (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .ready_in(ready_r),
    .valid_weight_in(valid_weight_in), .weight_in(weight_in), .weights_loaded(loaded_r),
    .stride2(stride2), .pxl_out(pxl_out_r), .valid_out(valid_out_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rnd16();
    logic signed [DW-1:0] t;
    t = DW'($urandom);
    return int'(t);
  endfunction

  // Fixed-point dot product of the current pixel with weight row co, then shift/saturate/ReLU.
  function automatic logic [DW-1:0] ref_out(input int co, input bit use_relu);
    longint acc;
    longint r;
    acc = 0;
    for (int ci = 0; ci < CIN; ci++) acc += longint'(m_w[co*CIN+ci]) * longint'(m_p[ci]);
    r = acc >>> FRAC;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    if (use_relu && r < 0) r = 0;
    return r[DW-1:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    valid_in = 1'b0;
    valid_weight_in = 1'b0;
    reset = 1'b1;
    m_pix = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_in, 0);
    chk("rst_loaded", weights_loaded, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_pxl", pxl_out, 0);
    reset = 1'b0;
  endtask

  task automatic load_weights();
    for (int i = 0; i < CIN*COUT; i++) begin
      chk("load_ready", ready_in, 0);
      chk("load_flag", weights_loaded, 0);
      weight_in = DW'(m_w[i]);
      valid_weight_in = 1'b1;
      @(negedge clk);
    end
    chk("loaded", weights_loaded, 1);
    chk("loaded_relu", loaded_r, 1);
    chk("loaded_ready", ready_in, 1);
    valid_weight_in = 1'b1;
    weight_in = 16'h5A5A;
  endtask

  task automatic send_pixel(input int gap);
    int  row, col, g;
    bit  keep;
    bit  vexp;
    int  co;
    valid_in = 1'b0;
    repeat (gap) @(negedge clk);
    if (m_pix == 0) m_stride = stride2;
    row = m_pix / IW;
    col = m_pix % IW;
    keep = !m_stride || ((row % 2 == 0) && (col % 2 == 0));
    m_pix = (m_pix + 1) % (IW*IH);
    for (int ci = 0; ci < CIN; ci++) begin
      pxl_in = DW'(m_p[ci]);
      valid_in = 1'b1;
      g = 0;
      while (!ready_in && g < 200) begin
        @(negedge clk);
        g++;
      end
      chk("ready_wait", ready_in, 1);
      @(posedge clk);
      @(negedge clk);
    end
    valid_in = 1'b0;
    if (keep) begin
      for (int j = 1; j <= CIN*COUT+1; j++) begin
        vexp = (j >= CIN+1) && ((j-1) % CIN == 0);
        co = (j-1)/CIN - 1;
        chk("valid_out", valid_out, vexp);
        chk("valid_out_relu", valid_out_r, vexp);
        if (vexp) begin
          chk("pxl_out", pxl_out, ref_out(co, 0));
          chk("pxl_out_relu", pxl_out_r, ref_out(co, 1));
        end
        chk("compute_ready", ready_in, (j == CIN*COUT+1));
        if (j < CIN*COUT+1) @(negedge clk);
      end
    end else begin
      chk("drop_ready", ready_in, 1);
      chk("drop_valid", valid_out, 0);
    end
  endtask

  task automatic set_t1();
    m_w[0] = 'h0100; m_w[1] = 'h0200; m_w[2] = 'h0080; m_w[3] = -256;
    m_p[0] = 'h0100; m_p[1] = 'h0200;
  endtask

  initial begin
    // Reset state, then weights loaded while valid_in is already held high
    do_reset();
    set_t1();
    stride2 = 1'b0;
    pxl_in = DW'(m_p[0]);
    valid_in = 1'b1;
    load_weights();
    send_pixel(0);

    // Rest of frame 0, every pixel kept
    for (int k = 1; k < IW*IH; k++) begin
      for (int ci = 0; ci < CIN; ci++) m_p[ci] = rnd16();
      send_pixel(k % 3);
    end

    // Stride-2 frame with stride2 dropped mid-frame
    stride2 = 1'b1;
    for (int k = 0; k < IW*IH; k++) begin
      if (k == 5) stride2 = 1'b0;
      for (int ci = 0; ci < CIN; ci++) m_p[ci] = rnd16();
      send_pixel(0);
    end

    // Random weights, random stride per frame with random toggles
    do_reset();
    for (int i = 0; i < CIN*COUT; i++) m_w[i] = rnd16();
    load_weights();
    for (int f = 0; f < 2; f++) begin
      stride2 = 1'($urandom);
      for (int k = 0; k < IW*IH; k++) begin
        if (k > 0 && $urandom_range(0, 3) == 0) stride2 = ~stride2;
        for (int ci = 0; ci < CIN; ci++) m_p[ci] = rnd16();
        send_pixel($urandom_range(0, 2));
      end
    end

    // Reset in the middle of COMPUTE, then reload and repeat the first pixel
    do_reset();
    set_t1();
    stride2 = 1'b0;
    load_weights();
    for (int ci = 0; ci < CIN; ci++) begin
      pxl_in = DW'(m_p[ci]);
      valid_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_valid", valid_out, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_valid", valid_out, 0);
    chk("async_ready", ready_in, 0);
    chk("async_loaded", weights_loaded, 0);
    do_reset();
    load_weights();
    send_pixel(0);

    // Saturation, both directions
    do_reset();
    for (int i = 0; i < CIN*COUT; i++) m_w[i] = 'h7FFF;
    load_weights();
    m_p[0] = 'h7FFF; m_p[1] = 'h7FFF;
    send_pixel(0);
    chk("sat_pos", pxl_out, 16'h7FFF);
    m_p[0] = -'h7FFF; m_p[1] = -'h7FFF;
    send_pixel(1);
    chk("sat_neg", pxl_out, 16'h8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
